// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry FIFO between instruction fetch (IF) and decode (ID).
//
// Each entry holds a PC, an instruction and opaque branch-predictor metadata.
// Both sides use a valid/ready handshake. The ID outputs read all-zero (a NOP
// bubble at PC 0) while the queue is empty. Flush drops every entry in one cycle.
//
// Ports:
//   clk, rst    clock; synchronous, active-high reset (clears pointers, count, storage)
//   flush       drop all entries at the next edge; the entry offered this cycle is dropped too
//   if_valid    fetch offers {if_pc, if_inst, if_meta}
//   if_ready    queue can accept an entry (registered state only)
//   id_valid    head entry valid
//   id_ready    decode consumes the head this cycle
//   id_pc, id_inst, id_meta   head entry, or zero when the queue is empty
//   count       current occupancy, 0..DEPTH
module if_id_queue #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned META_W = 12,
    parameter int unsigned DEPTH  = 4,   // power of two, >= 2
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    input  logic [META_W-1:0] if_meta,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [META_W-1:0] id_meta,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = ADDR_W + INST_W + META_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    // Handshake status comes from registered state only, so if_ready has no
    // combinational path from id_ready.
    assign if_ready = (count_q != CNT_W'(DEPTH));
    assign id_valid = (count_q != '0);
    assign count    = count_q;

    assign push = if_valid & if_ready & ~flush;
    assign pop  = id_valid & id_ready & ~flush;

    assign head = mem_q[rd_ptr_q];

    // Empty queue presents a zero bubble toward ID.
    always_comb begin
        id_pc   = '0;
        id_inst = '0;
        id_meta = '0;
        if (id_valid) begin
            {id_pc, id_inst, id_meta} = head;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Storage is left as is; count=0 already hides it.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {if_pc, if_inst, if_meta};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Testbench for if_id_queue: directed scenarios followed by randomized traffic,
// checked against a queue-based reference model with a scoreboard monitor.
module tb_if_id_queue;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;
    localparam int unsigned META_W = 12;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic [META_W-1:0] meta;
    } ent_t;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              if_valid;
    logic              if_ready;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic [META_W-1:0] if_meta;
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic [META_W-1:0] id_meta;
    logic [CNT_W-1:0]  count;

    int checks   = 0;
    int failures = 0;

    ent_t model[$];      // expected queue contents, head at index 0
    bit   chk_en = 0;    // set once the first reset edge has been seen

    if_id_queue #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .META_W (META_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_meta  (if_meta),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_meta  (id_meta),
        .count    (count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare against the model at the falling edge, then
    // apply the handshake the coming rising edge will perform.
    always @(negedge clk) begin
        ent_t e;
        bit   do_push;
        bit   do_pop;
        if (chk_en) begin
            chk("count", 64'(count), 64'(model.size()));
            chk("if_ready", 64'(if_ready), 64'(model.size() != DEPTH));
            chk("id_valid", 64'(id_valid), 64'(model.size() != 0));
            if (model.size() == 0) begin
                chk("bubble", {id_pc, id_inst, id_meta}, 64'(0));
                chk("bubble_meta", 64'(id_meta), 64'(0));
            end else begin
                e = model[0];
                chk("head_pc", 64'(id_pc), 64'(e.pc));
                chk("head_inst", 64'(id_inst), 64'(e.inst));
                chk("head_meta", 64'(id_meta), 64'(e.meta));
            end
        end
        if (rst) begin
            model.delete();
            chk_en = 1;
        end else if (flush) begin
            model.delete();
        end else begin
            do_pop  = (model.size() != 0) && id_ready;
            do_push = if_valid && (model.size() != DEPTH);
            if (do_pop) void'(model.pop_front());
            if (do_push) model.push_back('{pc: if_pc, inst: if_inst, meta: if_meta});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [ADDR_W-1:0] pc, input logic [INST_W-1:0] inst,
                         input logic [META_W-1:0] meta);
        if_valid = 1;
        if_pc    = pc;
        if_inst  = inst;
        if_meta  = meta;
    endtask

    task automatic idle_in();
        if_valid = 0;
        if_pc    = '0;
        if_inst  = '0;
        if_meta  = '0;
    endtask

    task automatic push_n(input int n, input logic [ADDR_W-1:0] base);
        id_ready = 0;
        for (int i = 0; i < n; i++) begin
            offer(base + ADDR_W'(4 * i), $urandom, META_W'($urandom));
            step();
        end
        idle_in();
    endtask

    task automatic drain();
        idle_in();
        id_ready = 1;
        repeat (DEPTH + 1) step();
        id_ready = 0;
    endtask

    initial begin
        rst = 1;
        flush = 0;
        id_ready = 0;
        idle_in();
        step();
        step();
        rst = 0;
        step();
        step();

        // Single pass-through.
        offer(32'h100, 32'h2401_0005, 12'hABC);
        step();
        idle_in();
        @(negedge clk);
        chk("pass_pc", 64'(id_pc), 64'h100);
        chk("pass_meta", 64'(id_meta), 64'hABC);
        step();
        drain();

        // Fill and back-pressure: 0x10 must not be accepted.
        push_n(5, 32'h0);
        @(negedge clk);
        chk("full_count", 64'(count), 64'd4);
        chk("full_if_ready", 64'(if_ready), 64'd0);
        step();
        drain();

        // Steady-state push+pop at count 2 across pointer wrap.
        push_n(2, 32'h1000);
        id_ready = 1;
        for (int i = 0; i < 10; i++) begin
            offer(32'h2000 + 32'(4 * i), $urandom, META_W'($urandom));
            step();
        end
        drain();

        // Flush with a simultaneous offer that must be dropped.
        push_n(3, 32'h3000);
        flush = 1;
        id_ready = 1;
        offer(32'h200, 32'h1, 12'h1);
        step();
        flush = 0;
        id_ready = 0;
        offer(32'h300, 32'h2, 12'h2);
        step();
        drain();

        // Reset mid-stream.
        push_n(3, 32'h4000);
        rst = 1;
        id_ready = 1;
        offer(32'h500, 32'h3, 12'h3);
        step();
        rst = 0;
        idle_in();
        repeat (4) step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 4) != 0) offer($urandom, $urandom, META_W'($urandom));
            else idle_in();
            id_ready = ($urandom % 3) != 0;
            flush    = ($urandom % 40) == 0;
            rst      = ($urandom % 300) == 0;
            step();
        end
        rst = 0;
        flush = 0;
        drain();
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry FIFO between fetch and decode.
- Carries PC, instruction and an opaque branch-predictor metadata vector (taken prediction, predictor select, global history) per entry.
- Decouples fetch from decode stalls with a valid/ready handshake on both sides.
- Supports a single-cycle flush on branch mispredict and inserts a zero bubble toward ID when empty.

Parameters:
- ADDR_W, 32, PC width.
- INST_W, 32, instruction width.
- META_W, 12, predictor metadata width (bit0 pdt_res, bit1 which_pdt, [11:2] history).
- DEPTH, 4, number of entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all entries (mispredict/exception redirect).
- if_valid  in  1  fetch presents an entry.
- if_ready  out  1  queue accepts an entry this cycle.
- if_pc  in  ADDR_W  fetched PC.
- if_inst  in  INST_W  fetched instruction.
- if_meta  in  META_W  predictor metadata.
- id_valid  out  1  head entry valid.
- id_ready  in  1  decode consumes the head this cycle (not stalled).
- id_pc  out  ADDR_W  head PC.
- id_inst  out  INST_W  head instruction.
- id_meta  out  META_W  head metadata.
- count  out  CNT_W  current occupancy.

Behaviour:
- Reset: clk and rst as decided: synchronous, active-high. On a rising edge with rst=1: rd_ptr=0, wr_ptr=0, count=0, all storage zeroed. Outputs then read id_valid=0, id_pc=0, id_inst=0, id_meta=0, count=0, if_ready=1.
- Priority: rst > flush > push/pop. Reset asserted mid-operation discards everything, with no partial pops.
- Storage: circular buffer of DEPTH entries, width ADDR_W+INST_W+META_W. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- if_ready = (count != DEPTH). It depends only on registered state; no combinational path from id_ready.
- push = if_valid & if_ready & ~flush.
- pop = id_valid & id_ready & ~flush.
- id_valid = (count != 0).
- id_pc, id_inst and id_meta show the head entry when id_valid=1. They are forced to all-zero when count==0 (bubble, equivalent to a NOP at PC 0).
- Latency: an entry pushed at edge N is visible at the ID outputs after edge N if the queue was empty. There is no same-cycle bypass from IF to ID.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal at any count from 1 to DEPTH-1.
- When full: if_ready=0, so no push occurs even if pop=1 that cycle. if_ready rises on the next cycle.
- When empty: pop cannot occur because id_valid=0.
- Flush: at the next edge, count=0, rd_ptr=wr_ptr=0, and the entry offered in the flush cycle is dropped. Storage contents need not be cleared, but outputs read zero because count=0. During the flush cycle itself, outputs still show the pre-flush head; consumers must qualify with flush.
- count arithmetic: count_next = count + push − pop. It never exceeds DEPTH and never underflows.
- Metadata is stored and returned bit-exact; the queue never interprets it.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then if_valid=0 → id_valid=0, id_pc=0, id_inst=0, id_meta=0, count=0, if_ready=1.
- Single pass-through: push pc=0x100, inst=0x24010005, meta=0xABC at edge N with id_ready=0 → after N: id_valid=1, id_pc=0x100, id_inst=0x24010005, id_meta=0xABC, count=1.
- Fill and back-pressure (DEPTH=4): id_ready=0, push pc 0x0,0x4,0x8,0xC,0x10 on consecutive cycles → count=4, if_ready=0, 0x10 not accepted. Then id_ready=1 → pops in order 0x0,0x4,0x8,0xC; if_ready=1 one cycle after the first pop.
- Simultaneous push/pop with wrap: keep count=2 while streaming 10 entries → output order matches input order across pointer wrap, count stays 2.
- Flush: count=3, flush=1 together with if_valid=1 (pc=0x200) → next cycle count=0, id_valid=0, outputs zero, and 0x200 never appears. A push on the following cycle appears normally.
- Reset mid-stream: count=3, rst=1 together with if_valid=1 and id_ready=1 → next cycle count=0, id_valid=0, and no entry emerges afterwards.
